// File: rtl/fx2_bus_scheduler_pkg.sv
// Shared types for the FX2 slave-FIFO bus scheduler.
// States, endpoint addresses and grant encoding.
package fx2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_SETUP,
    S_RX_READ,
    S_TX_SETUP,
    S_TX_WRITE,
    S_TX_PKTEND,
    S_TURN
  } fx2_state_e;

  typedef enum logic {
    GRANT_RX,
    GRANT_TX
  } grant_e;

  localparam logic [1:0] FX2_EP2_ADDR = 2'b00;
  localparam logic [1:0] FX2_EP6_ADDR = 2'b10;

endpackage

// File: rtl/fx2_bus_scheduler.sv
// Time-shares the FX2 slave-FIFO bus between EP2 reads and
// EP6 writes with round-robin grants and bounded bursts.
module fx2_bus_scheduler
  import fx2_pkg::*;
#(
  parameter int BURST_MAX = 256,
  parameter int CNT_W     = $clog2(BURST_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fx2_flaga,
  input  logic        fx2_flagd,
  output logic        fx2_slcs_n,
  output logic        fx2_slrd_n,
  output logic        fx2_sloe_n,
  output logic        fx2_slwr_n,
  output logic        fx2_pktend_n,
  output logic [1:0]  fx2_a,
  input  logic [15:0] fx2_db_in,
  output logic [15:0] fx2_db_out,
  output logic        fx2_db_oe,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [15:0] rx_data,
  input  logic        tx_valid,
  input  logic [15:0] tx_data,
  input  logic        tx_last,
  output logic        tx_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  fx2_state_e       state_q, state_d;
  grant_e           grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_fire;
  logic             wr_fire;
  logic             room;
  logic             rx_elig;
  logic             tx_elig;
  logic             pick_rx;
  logic             pick_tx;

  assign rx_elig = fx2_flaga & rx_ready;
  assign tx_elig = fx2_flagd & tx_valid;
  assign room    = cnt_q < CNT_MAX;

  // When both sides want the bus, the one not served last wins.
  assign pick_rx = rx_elig & (~tx_elig | (grant_q == GRANT_TX));
  assign pick_tx = tx_elig & (~rx_elig | (grant_q == GRANT_RX));

  assign fx2_slcs_n = rst;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    rd_fire      = 1'b0;
    wr_fire      = 1'b0;
    fx2_slrd_n   = 1'b1;
    fx2_sloe_n   = 1'b1;
    fx2_slwr_n   = 1'b1;
    fx2_pktend_n = 1'b1;
    fx2_a        = FX2_EP2_ADDR;
    fx2_db_oe    = 1'b0;
    fx2_db_out   = '0;
    tx_ready     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          pick_rx: begin
            state_d = S_RX_SETUP;
            grant_d = GRANT_RX;
            cnt_d   = '0;
          end
          pick_tx: begin
            state_d = S_TX_SETUP;
            grant_d = GRANT_TX;
            cnt_d   = '0;
          end
          default: ;
        endcase
      end
      S_RX_SETUP: begin
        fx2_sloe_n = 1'b0;
        state_d    = S_RX_READ;
      end
      S_RX_READ: begin
        fx2_sloe_n = 1'b0;
        rd_fire    = rx_elig & room;
        fx2_slrd_n = ~rd_fire;
        if (rd_fire) cnt_d = cnt_q + CNT_W'(1);
        else         state_d = S_TURN;
      end
      S_TX_SETUP: begin
        fx2_a     = FX2_EP6_ADDR;
        fx2_db_oe = 1'b1;
        state_d   = S_TX_WRITE;
      end
      S_TX_WRITE: begin
        fx2_a      = FX2_EP6_ADDR;
        fx2_db_oe  = 1'b1;
        fx2_db_out = tx_data;
        tx_ready   = fx2_flagd & room;
        wr_fire    = tx_valid & fx2_flagd & room;
        fx2_slwr_n = ~wr_fire;
        if (wr_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (tx_last) state_d = S_TX_PKTEND;
        end else begin
          state_d = S_TURN;
        end
      end
      S_TX_PKTEND: begin
        fx2_a        = FX2_EP6_ADDR;
        fx2_db_oe    = 1'b1;
        fx2_pktend_n = 1'b0;
        state_d      = S_TURN;
      end
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= GRANT_TX;
      cnt_q    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      rx_valid <= rd_fire;
      if (rd_fire) rx_data <= fx2_db_in;
    end
  end

endmodule

// File: tb/tb_fx2_bus_scheduler.sv
// Directed bench for fx2_bus_scheduler with BURST_MAX=4,
// plus a random run watched by bus-conflict checks.
module tb_fx2_bus_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        fx2_flaga;
  logic        fx2_flagd;
  logic        fx2_slcs_n;
  logic        fx2_slrd_n;
  logic        fx2_sloe_n;
  logic        fx2_slwr_n;
  logic        fx2_pktend_n;
  logic [1:0]  fx2_a;
  logic [15:0] fx2_db_in;
  logic [15:0] fx2_db_out;
  logic        fx2_db_oe;
  logic        rx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_last;
  logic        tx_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fx2_bus_scheduler #(.BURST_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .fx2_flaga    (fx2_flaga),
    .fx2_flagd    (fx2_flagd),
    .fx2_slcs_n   (fx2_slcs_n),
    .fx2_slrd_n   (fx2_slrd_n),
    .fx2_sloe_n   (fx2_sloe_n),
    .fx2_slwr_n   (fx2_slwr_n),
    .fx2_pktend_n (fx2_pktend_n),
    .fx2_a        (fx2_a),
    .fx2_db_in    (fx2_db_in),
    .fx2_db_out   (fx2_db_out),
    .fx2_db_oe    (fx2_db_oe),
    .rx_ready     (rx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready)
  );

  task automatic expect_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus ownership may only change hands through an idle cycle.
  logic mon_en  = 1'b0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      expect_eq("oe_clash", 32'(!fx2_sloe_n && fx2_db_oe), 0);
      expect_eq("strobe_clash",
                32'(!fx2_slrd_n && !fx2_slwr_n), 0);
      expect_eq("gap_rd_to_wr", 32'(prev_rd && fx2_db_oe), 0);
      expect_eq("gap_wr_to_rd", 32'(prev_wr && !fx2_sloe_n), 0);
      prev_rd = !fx2_sloe_n;
      prev_wr = fx2_db_oe;
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    fx2_flaga = 1'b0;
    fx2_flagd = 1'b0;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_last   = 1'b0;
    tx_data   = '0;
    fx2_db_in = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  logic [7:0]  t1_slrd  = 8'b11000011;
  logic [7:0]  t1_sloe  = 8'b10000001;
  logic [7:0]  t1_rxv   = 8'b01111000;
  logic [6:0]  t3_slwr  = 7'b1100011;
  logic [6:0]  t3_pkt   = 7'b1011111;
  logic [6:0]  t3_oe    = 7'b0111110;
  logic [9:0]  t4_slrd  = 10'b0011110011;
  logic [9:0]  t4_sloe  = 10'b0001100001;
  logic [9:0]  t4_rxv   = 10'b1000011000;
  logic [15:0] words [3];
  int          run_kind [16];
  int          run_len  [16];
  int          nruns;
  int          cur_kind;
  int          cur_len;
  int          k;
  int          strobes;
  int          idx;
  logic        acc;

  initial begin
    words[0] = 16'hAAAA;
    words[1] = 16'hBBBB;
    words[2] = 16'hCCCC;

    // reset values
    do_reset();
    mon_en = 1'b1;
    @(negedge clk);
    expect_eq("rst_slcs",   32'(fx2_slcs_n), 1);
    expect_eq("rst_slrd",   32'(fx2_slrd_n), 1);
    expect_eq("rst_sloe",   32'(fx2_sloe_n), 1);
    expect_eq("rst_slwr",   32'(fx2_slwr_n), 1);
    expect_eq("rst_pktend", 32'(fx2_pktend_n), 1);
    expect_eq("rst_a",      32'(fx2_a), 0);
    expect_eq("rst_oe",     32'(fx2_db_oe), 0);
    expect_eq("rst_dbout",  32'(fx2_db_out), 0);
    expect_eq("rst_rxv",    32'(rx_valid), 0);
    expect_eq("rst_rxd",    32'(rx_data), 0);
    expect_eq("rst_txr",    32'(tx_ready), 0);

    // RX burst capped at BURST_MAX
    @(posedge clk); #1;
    fx2_db_in = 16'h0123;
    fx2_flaga = 1'b1;
    rx_ready  = 1'b1;
    rst       = 1'b0;
    strobes   = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) expect_eq("t1_slcs", 32'(fx2_slcs_n), 0);
      expect_eq("t1_slrd", 32'(fx2_slrd_n), 32'(t1_slrd[i]));
      expect_eq("t1_sloe", 32'(fx2_sloe_n), 32'(t1_sloe[i]));
      expect_eq("t1_rxv",  32'(rx_valid),   32'(t1_rxv[i]));
      if (i >= 3 && i <= 6)
        expect_eq("t1_rxd", 32'(rx_data), 32'(16'h0123 + i - 3));
      if (i == 2) expect_eq("t1_a", 32'(fx2_a), 0);
      acc = !fx2_slrd_n;
      if (acc) strobes++;
      @(posedge clk); #1;
      if (acc) fx2_db_in = fx2_db_in + 16'd1;
      if (i == 6) fx2_flaga = 1'b0;
    end
    expect_eq("t1_strobes", strobes, 4);

    // round-robin with both sides always eligible
    do_reset();
    fx2_flaga = 1'b1;
    rx_ready  = 1'b1;
    fx2_flagd = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 16'h7777;
    rst       = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_kind[i] = 0;
      run_len[i]  = 0;
    end
    nruns    = 0;
    cur_kind = 0;
    cur_len  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      k = !fx2_slrd_n ? 1 : (!fx2_slwr_n ? 2 : 0);
      if (k != 0) begin
        if (k == cur_kind) begin
          cur_len++;
        end else begin
          if (cur_kind != 0 && nruns < 16) begin
            run_kind[nruns] = cur_kind;
            run_len[nruns]  = cur_len;
            nruns++;
          end
          cur_kind = k;
          cur_len  = 1;
        end
      end
      @(posedge clk); #1;
    end
    if (cur_kind != 0 && nruns < 16) begin
      run_kind[nruns] = cur_kind;
      run_len[nruns]  = cur_len;
      nruns++;
    end
    expect_eq("t2_nruns", 32'(nruns >= 4), 1);
    for (int r = 0; r < 4; r++) begin
      expect_eq("t2_kind", run_kind[r], (r % 2 == 0) ? 1 : 2);
      expect_eq("t2_len",  run_len[r], 4);
    end

    // TX packet of three words with pktend
    do_reset();
    fx2_flagd = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = words[0];
    tx_last   = 1'b0;
    idx       = 0;
    strobes   = 0;
    rst       = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      expect_eq("t3_slwr", 32'(fx2_slwr_n),   32'(t3_slwr[i]));
      expect_eq("t3_pkt",  32'(fx2_pktend_n), 32'(t3_pkt[i]));
      expect_eq("t3_oe",   32'(fx2_db_oe),    32'(t3_oe[i]));
      if (i >= 2 && i <= 4) begin
        expect_eq("t3_dout", 32'(fx2_db_out), 32'(words[i-2]));
        expect_eq("t3_a",    32'(fx2_a), 2);
      end
      acc = tx_valid && tx_ready;
      if (!fx2_slwr_n) strobes++;
      @(posedge clk); #1;
      if (acc) idx++;
      tx_valid = idx < 3;
      tx_data  = (idx < 3) ? words[idx] : 16'h0000;
      tx_last  = idx == 2;
    end
    expect_eq("t3_strobes", strobes, 3);

    // flag drop mid-burst, then resume without loss
    do_reset();
    fx2_db_in = 16'h1000;
    fx2_flaga = 1'b1;
    rx_ready  = 1'b1;
    rst       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_eq("t4_slrd", 32'(fx2_slrd_n), 32'(t4_slrd[i]));
      expect_eq("t4_sloe", 32'(fx2_sloe_n), 32'(t4_sloe[i]));
      expect_eq("t4_rxv",  32'(rx_valid),   32'(t4_rxv[i]));
      if (i == 3) expect_eq("t4_rxd0", 32'(rx_data), 32'h1000);
      if (i == 4) expect_eq("t4_rxd1", 32'(rx_data), 32'h1001);
      if (i == 9) expect_eq("t4_rxd2", 32'(rx_data), 32'h1002);
      acc = !fx2_slrd_n;
      @(posedge clk); #1;
      if (acc) fx2_db_in = fx2_db_in + 16'd1;
      if (i == 3) fx2_flaga = 1'b0;
      if (i == 5) fx2_flaga = 1'b1;
    end

    // reset while driving the bus
    do_reset();
    fx2_flagd = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 16'h5555;
    rst       = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    expect_eq("t5_oe_before", 32'(fx2_db_oe), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    expect_eq("t5_slcs_rst", 32'(fx2_slcs_n), 1);
    @(posedge clk); #1;
    @(negedge clk);
    expect_eq("t5_oe",   32'(fx2_db_oe), 0);
    expect_eq("t5_slwr", 32'(fx2_slwr_n), 1);
    expect_eq("t5_slrd", 32'(fx2_slrd_n), 1);
    expect_eq("t5_sloe", 32'(fx2_sloe_n), 1);
    expect_eq("t5_pkt",  32'(fx2_pktend_n), 1);
    expect_eq("t5_a",    32'(fx2_a), 0);
    @(posedge clk); #1;
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    expect_eq("t5_pkt_after", 32'(fx2_pktend_n), 1);
    expect_eq("t5_slcs_run",  32'(fx2_slcs_n), 0);

    // random traffic; the monitor checks every cycle
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      fx2_flaga = 1'($urandom_range(0, 1));
      fx2_flagd = 1'($urandom_range(0, 1));
      rx_ready  = 1'($urandom_range(0, 1));
      tx_valid  = 1'($urandom_range(0, 1));
      tx_last   = $urandom_range(0, 3) == 0;
      tx_data   = 16'($urandom);
      fx2_db_in = 16'($urandom);
    end
    @(negedge clk);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
